// File: rtl/user_proj_example_ann.sv
// Wishbone-attached kd-tree approximate-nearest-neighbour search engine.
// Firmware loads tree, leaves and queries; the engine stores the best patch index per query.
module user_proj_example_ann #(
  parameter int BITS = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BITS-1:0] wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BITS-1:0] wbs_dat_o,
  input  logic [127:0]    la_data_in,
  output logic [127:0]    la_data_out,
  input  logic [127:0]    la_oenb,
  input  logic [37:0]     io_in,
  output logic [37:0]     io_out,
  output logic [37:0]     io_oeb,
  output logic [2:0]      irq
);

  localparam int NUM_QUERYS   = 494;
  localparam int NUM_NODES    = 63;
  localparam int LEAF_ENTRIES = 64 * 8;
  localparam int PATCH_SIZE   = 5;
  localparam int DATA_WIDTH   = 11;

  localparam logic [12:0] QUERY_LIMIT = 13'(NUM_QUERYS);
  localparam logic [12:0] LEAF_LIMIT  = 13'(LEAF_ENTRIES);
  localparam logic [12:0] NODE_LIMIT  = 13'(NUM_NODES);
  localparam logic [8:0]  LAST_QUERY  = 9'(NUM_QUERYS - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRAVERSE, S_COMPARE, S_WRITE} state_t;

  state_t state, state_nxt;

  logic [21:0]     node_mem [NUM_NODES];
  logic [BITS-1:0] leaf_lo  [LEAF_ENTRIES];
  logic [BITS-1:0] leaf_hi  [LEAF_ENTRIES];
  logic [BITS-1:0] q_lo     [NUM_QUERYS];
  logic [BITS-1:0] q_hi     [NUM_QUERYS];
  logic [8:0]      best_mem [NUM_QUERYS];

  logic [31:0]     mode_reg, debug_reg;
  logic            done, busy;
  logic [2:0]      step;
  logic [6:0]      node_idx;
  logic [8:0]      q_idx;
  logic [13:0]     best_sad, sad;
  logic [8:0]      best_idx, cand_idx;

  logic [15:0]     region, roff;
  logic [12:0]     ent;
  logic            word, req, wr, rd, mem_wr, start_req;
  logic [BITS-1:0] rdata;

  logic [54:0]     q_vec, l_vec;
  logic [21:0]     node_word;
  logic [10:0]     q_split;
  logic            go_left;
  logic [6:0]      leaf_num;
  logic [8:0]      leaf_addr;

  assign region    = wbs_adr_i[31:16];
  assign roff      = wbs_adr_i[15:0];
  assign ent       = wbs_adr_i[15:3];
  assign word      = wbs_adr_i[2];
  assign req       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr        = req & wbs_we_i;
  assign rd        = req & ~wbs_we_i;
  assign busy      = (state != S_IDLE);
  assign mem_wr    = wr & ~busy;
  assign start_req = wr && region == 16'h3000 && roff == 16'h000C && !busy;

  assign la_data_out = '0;
  assign io_out      = {6'b0, done, 31'b0};
  assign io_oeb      = {6'h3F, 1'b0, 31'h7FFF_FFFF};
  assign irq         = {2'b0, done};

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_sel_i, la_data_in, la_oenb, io_in, leaf_num[6]};

  function automatic logic [13:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? 14'(a - b) : 14'(b - a);
  endfunction

  // Bus handshake, read data capture and the two scratch registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      mode_reg  <= '0;
      debug_reg <= '0;
    end else begin
      wbs_ack_o <= req;
      if (rd) wbs_dat_o <= rdata;
      if (wr && region == 16'h3000 && roff == 16'h0000) mode_reg  <= wbs_dat_i;
      if (wr && region == 16'h3000 && roff == 16'h0004) debug_reg <= wbs_dat_i;
    end
  end

  always_comb begin
    rdata = '0;
    case (region)
      16'h3000: begin
        case (roff)
          16'h0000: rdata = mode_reg;
          16'h0004: rdata = debug_reg;
          16'h0008: rdata = {31'b0, done};
          16'h0010: rdata = {31'b0, busy};
          default:  rdata = '0;
        endcase
      end
      16'h3001: if (ent < QUERY_LIMIT) rdata = word ? q_hi[ent[8:0]] : q_lo[ent[8:0]];
      16'h3002: if (ent < LEAF_LIMIT) rdata = word ? leaf_hi[ent[8:0]] : leaf_lo[ent[8:0]];
      16'h3003: if (ent < QUERY_LIMIT) rdata = {23'b0, best_mem[ent[8:0]]};
      16'h3004: if (ent < NODE_LIMIT && !word) rdata = {10'b0, node_mem[ent[5:0]]};
      default:  rdata = '0;
    endcase
  end

  // Host-loaded memories hold their contents across reset
  always_ff @(posedge wb_clk_i) begin
    if (mem_wr && region == 16'h3004 && ent < NODE_LIMIT && !word)
      node_mem[ent[5:0]] <= wbs_dat_i[21:0];
    if (mem_wr && region == 16'h3002 && ent < LEAF_LIMIT) begin
      if (word) leaf_hi[ent[8:0]] <= wbs_dat_i;
      else      leaf_lo[ent[8:0]] <= wbs_dat_i;
    end
    if (mem_wr && region == 16'h3001 && ent < QUERY_LIMIT) begin
      if (word) q_hi[ent[8:0]] <= wbs_dat_i;
      else      q_lo[ent[8:0]] <= wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (state == S_WRITE) best_mem[q_idx] <= best_idx;
  end

  assign q_vec     = {q_hi[q_idx][22:0], q_lo[q_idx]};
  assign node_word = node_mem[node_idx[5:0]];
  assign leaf_num  = node_idx - 7'd63;
  assign leaf_addr = {leaf_num[5:0], step};
  assign l_vec     = {leaf_hi[leaf_addr][22:0], leaf_lo[leaf_addr]};
  assign cand_idx  = leaf_hi[leaf_addr][31:23];

  // Component of the query selected by the current node's split dimension
  always_comb begin
    q_split = q_vec[10:0];
    case (node_word[10:0])
      11'd1:   q_split = q_vec[21:11];
      11'd2:   q_split = q_vec[32:22];
      11'd3:   q_split = q_vec[43:33];
      11'd4:   q_split = q_vec[54:44];
      default: q_split = q_vec[10:0];
    endcase
  end

  assign go_left = (q_split < node_word[21:11]);

  always_comb begin
    sad = '0;
    for (int k = 0; k < PATCH_SIZE; k++)
      sad = sad + abs_diff(q_vec[k*DATA_WIDTH +: DATA_WIDTH], l_vec[k*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_req) state_nxt = S_TRAVERSE;
      S_TRAVERSE: if (step == 3'd5) state_nxt = S_COMPARE;
      S_COMPARE:  if (step == 3'd7) state_nxt = S_WRITE;
      S_WRITE:    state_nxt = (q_idx == LAST_QUERY) ? S_IDLE : S_TRAVERSE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Per-query datapath: tree descent, running minimum, query advance and done flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      step     <= '0;
      node_idx <= '0;
      q_idx    <= '0;
      best_sad <= '0;
      best_idx <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req) begin
            done     <= 1'b0;
            q_idx    <= '0;
            step     <= '0;
            node_idx <= '0;
          end
        end
        S_TRAVERSE: begin
          node_idx <= go_left ? {node_idx[5:0], 1'b1} : {node_idx[5:0], 1'b0} + 7'd2;
          step     <= (step == 3'd5) ? 3'd0 : step + 3'd1;
        end
        S_COMPARE: begin
          if (step == 3'd0 || sad < best_sad) begin
            best_sad <= sad;
            best_idx <= cand_idx;
          end
          step <= step + 3'd1;
        end
        S_WRITE: begin
          node_idx <= '0;
          step     <= '0;
          if (q_idx == LAST_QUERY) done  <= 1'b1;
          else                     q_idx <= q_idx + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_proj_example_ann.sv
// Self-checking bench for the kd-tree search accelerator: register/memory access
// over Wishbone and full searches checked against a behavioural nearest-neighbour model.
module tb_user_proj_example_ann;

  localparam int NQ = 494;
  localparam int NN = 63;
  localparam int NE = 512;
  localparam int PS = 5;

  localparam logic [31:0] A_MODE  = 32'h3000_0000;
  localparam logic [31:0] A_DEBUG = 32'h3000_0004;
  localparam logic [31:0] A_DONE  = 32'h3000_0008;
  localparam logic [31:0] A_START = 32'h3000_000C;
  localparam logic [31:0] A_BUSY  = 32'h3000_0010;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = 4'hF;
  logic [31:0]  wbs_dat_i = '0, wbs_adr_i = '0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in = '0, la_oenb = '1;
  logic [127:0] la_data_out;
  logic [37:0]  io_in = '0;
  logic [37:0]  io_out, io_oeb;
  logic [2:0]   irq;

  user_proj_example_ann dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_data_in(la_data_in), .la_data_out(la_data_out), .la_oenb(la_oenb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int done_cycle = -1;
  logic prev_done = 1'b0;

  int node_dim [NN];
  int node_med [NN];
  int leaf_comp [NE][PS];
  int leaf_idx [NE];
  int qry [NQ][PS];

  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // Timestamp the rising edge of the done pin for runtime measurement
  always @(negedge wb_clk_i) begin
    if (io_out[31] && !prev_done) done_cycle = cyc_cnt;
    prev_done = io_out[31];
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] adr(input logic [15:0] region, input int e, input int w);
    return {region, 16'(e * 8 + w * 4)};
  endfunction

  task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, output int n);
    @(negedge wb_clk_i);
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1'b1; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge wb_clk_i); n++; end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) checkOutput("write_ack_timeout", wbs_ack_o, 1'b1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wbRead(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(negedge wb_clk_i);
    wbs_adr_i = a; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge wb_clk_i); n++; end while (!wbs_ack_o && n < 8);
    if (!wbs_ack_o) checkOutput("read_ack_timeout", wbs_ack_o, 1'b1);
    d = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
  endtask

  function automatic logic [63:0] pack_leaf(input int e);
    logic [63:0] v = '0;
    for (int k = 0; k < PS; k++) v[11*k +: 11] = 11'(leaf_comp[e][k]);
    v[63:55] = 9'(leaf_idx[e]);
    return v;
  endfunction

  function automatic logic [63:0] pack_query(input int q);
    logic [63:0] v = '0;
    for (int k = 0; k < PS; k++) v[11*k +: 11] = 11'(qry[q][k]);
    return v;
  endfunction

  // Reference: descend by split rule, then exhaustive L1 search in the reached leaf
  function automatic int model_leaf(input int q);
    int n;
    n = 0;
    for (int lvl = 0; lvl < 6; lvl++)
      n = (qry[q][node_dim[n]] < node_med[n]) ? 2 * n + 1 : 2 * n + 2;
    return n - NN;
  endfunction

  function automatic int model_best(input int q);
    int l, best, idx, sad, dif;
    l = model_leaf(q);
    best = 1 << 30;
    idx = 0;
    for (int s = 0; s < 8; s++) begin
      sad = 0;
      for (int k = 0; k < PS; k++) begin
        dif = qry[q][k] - leaf_comp[8 * l + s][k];
        sad += (dif < 0) ? -dif : dif;
      end
      if (sad < best) begin best = sad; idx = leaf_idx[8 * l + s]; end
    end
    return idx;
  endfunction

  task automatic applyStimulus();
    int n;
    logic [63:0] v;
    for (int i = 0; i < NN; i++)
      wbWrite(adr(16'h3004, i, 0), {10'b0, 11'(node_med[i]), 11'(node_dim[i])}, n);
    for (int e = 0; e < NE; e++) begin
      v = pack_leaf(e);
      wbWrite(adr(16'h3002, e, 0), v[31:0], n);
      wbWrite(adr(16'h3002, e, 1), v[63:32], n);
    end
    for (int q = 0; q < NQ; q++) begin
      v = pack_query(q);
      wbWrite(adr(16'h3001, q, 0), v[31:0], n);
      wbWrite(adr(16'h3001, q, 1), v[63:32], n);
    end
  endtask

  task automatic runSearch(input bit poke_busy);
    int t0, waited, n;
    logic [31:0] rd;
    logic [63:0] v;
    done_cycle = -1;
    wbWrite(A_START, 32'h0, n);
    t0 = cyc_cnt;
    checkOutput("done_clear_on_start", io_out[31], 1'b0);
    if (poke_busy) begin
      wbRead(A_BUSY, rd);
      checkOutput("busy_reg_running", rd, 32'h1);
      wbRead(A_DONE, rd);
      checkOutput("done_reg_running", rd, 32'h0);
      repeat (100) @(negedge wb_clk_i);
      wbWrite(A_START, 32'h0, n);
      v = pack_query(7);
      wbWrite(adr(16'h3001, 7, 0), ~v[31:0], n);
      wbRead(adr(16'h3001, 7, 0), rd);
      checkOutput("query_write_dropped_busy", rd, v[31:0]);
    end
    waited = 0;
    while (!io_out[31] && waited < 9000) begin @(negedge wb_clk_i); waited++; end
    #1;
    checkOutput("run_finished", io_out[31], 1'b1);
    checkOutput("run_cycles", 64'(done_cycle - t0), 64'd7410);
    checkOutput("irq_done", irq, 3'b001);
    wbRead(A_BUSY, rd);
    checkOutput("busy_reg_after", rd, 32'h0);
    wbRead(A_DONE, rd);
    checkOutput("done_reg_after", rd, 32'h1);
  endtask

  task automatic checkResults();
    logic [31:0] rd;
    for (int q = 0; q < NQ; q++) begin
      wbRead(adr(16'h3003, q, 0), rd);
      checkOutput($sformatf("best_q%0d", q), rd, 64'(model_best(q)));
    end
  endtask

  initial begin
    int n, l;
    logic [31:0] rd, val;

    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    checkOutput("reset_ack", wbs_ack_o, 1'b0);
    checkOutput("reset_io_out", io_out, 38'h0);
    checkOutput("reset_io_oeb", io_oeb, 38'h3F_7FFF_FFFF);
    checkOutput("reset_irq", irq, 3'b000);
    checkOutput("reset_la_out", la_data_out, 128'h0);
    wbRead(A_BUSY, rd);
    checkOutput("reset_busy_reg", rd, 32'h0);
    wbRead(A_MODE, rd);
    checkOutput("reset_mode", rd, 32'h0);

    // Registers, handshake timing and a strobe without cycle
    wbWrite(A_MODE, 32'h1, n);
    checkOutput("ack_latency", n, 1);
    @(negedge wb_clk_i);
    checkOutput("ack_single_pulse", wbs_ack_o, 1'b0);
    wbWrite(A_DEBUG, 32'h1, n);
    wbRead(A_MODE, rd);  checkOutput("mode_rb", rd, 32'h1);
    wbRead(A_DEBUG, rd); checkOutput("debug_rb", rd, 32'h1);
    for (int i = 0; i < 4; i++) begin
      val = $urandom;
      wbWrite(A_DEBUG, val, n);
      wbRead(A_DEBUG, rd);
      checkOutput("debug_rand_rb", rd, val);
    end
    wbRead(A_START, rd); checkOutput("start_reads_zero", rd, 32'h0);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checkOutput("no_ack_without_cyc", wbs_ack_o, 1'b0);
    wbs_stb_i = 1'b0;

    wbWrite(adr(16'h3004, 0, 0), {10'b0, 11'd55, 11'd1}, n);
    wbRead(adr(16'h3004, 0, 0), rd);
    checkOutput("node0_rb", rd, 32'h0001_B801);
    wbWrite(adr(16'h3002, 5, 0), 32'hDEAD_BEEF, n);
    wbWrite(adr(16'h3002, 5, 1), 32'h1234_5678, n);
    wbRead(adr(16'h3002, 5, 0), rd); checkOutput("leaf5_w0", rd, 32'hDEAD_BEEF);
    wbRead(adr(16'h3002, 5, 1), rd); checkOutput("leaf5_w1", rd, 32'h1234_5678);
    wbWrite(adr(16'h3001, 494, 0), 32'hCAFE_F00D, n);
    wbRead(adr(16'h3001, 494, 0), rd); checkOutput("query_oob_zero", rd, 32'h0);
    wbRead(adr(16'h3002, 600, 1), rd); checkOutput("leaf_oob_zero", rd, 32'h0);
    wbRead(32'h3005_0000, rd);        checkOutput("unmapped_zero", rd, 32'h0);

    // Scenario 1: degenerate tree routes by component 0 only; query 0 matches leaf 0 slot 3
    for (int i = 0; i < NN; i++) begin node_dim[i] = 0; node_med[i] = 1024; end
    for (int e = 0; e < NE; e++) begin
      for (int k = 0; k < PS; k++) leaf_comp[e][k] = $urandom_range(0, 2047);
      leaf_idx[e] = $urandom_range(0, 511);
    end
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < PS; k++) qry[q][k] = $urandom_range(0, 2047);
    qry[0][0] = 0;
    for (int s = 0; s < 8; s++) leaf_comp[s][0] = 100 + s;
    for (int k = 0; k < PS; k++) leaf_comp[3][k] = qry[0][k];
    leaf_idx[3] = 300;
    applyStimulus();
    runSearch(1'b0);
    wbRead(adr(16'h3003, 0, 0), rd); checkOutput("best0_w0_300", rd, 32'd300);
    wbRead(adr(16'h3003, 0, 1), rd); checkOutput("best0_w1_300", rd, 32'd300);
    checkResults();

    // Scenario 2: random tree, an exact-tie for query 7, busy-time pokes
    for (int i = 0; i < NN; i++) begin
      node_dim[i] = $urandom_range(0, 4);
      node_med[i] = $urandom_range(0, 2047);
    end
    for (int e = 0; e < NE; e++) begin
      for (int k = 0; k < PS; k++) leaf_comp[e][k] = $urandom_range(0, 2047);
      leaf_idx[e] = $urandom_range(0, 511);
    end
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < PS; k++) qry[q][k] = $urandom_range(0, 2047);
    l = model_leaf(7);
    for (int k = 0; k < PS; k++) begin
      leaf_comp[8 * l + 2][k] = qry[7][k];
      leaf_comp[8 * l + 5][k] = qry[7][k];
    end
    leaf_idx[8 * l + 2] = 17;
    leaf_idx[8 * l + 5] = 411;
    applyStimulus();
    runSearch(1'b1);
    wbRead(adr(16'h3003, 7, 1), rd); checkOutput("tie_lower_slot", rd, 32'd17);
    checkResults();

    // Reset during a run aborts the engine but keeps memory contents
    wbWrite(A_START, 32'h0, n);
    repeat (200) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("abort_done_pin", io_out[31], 1'b0);
    wb_rst_i = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    wbRead(A_BUSY, rd); checkOutput("abort_busy", rd, 32'h0);
    wbRead(A_DONE, rd); checkOutput("abort_done_reg", rd, 32'h0);
    wbRead(adr(16'h3004, 0, 0), rd);
    checkOutput("node0_kept", rd, {10'b0, 11'(node_med[0]), 11'(node_dim[0])});
    wbRead(adr(16'h3003, 300, 0), rd);
    checkOutput("best300_kept", rd, 64'(model_best(300)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
